// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiply sequencer.
// Optional op counter in booth_mult_seq is enabled by BOOTH_OPCNT_EN.
package booth_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Booth pair decode result
    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } op_t;

    // Decode {Q[0], Q[-1]}: 01 adds M, 10 subtracts M, 00/11 do nothing
    function automatic op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of the
// sign-extended multiplicand into A, then arithmetic shift right of
// {A, Q, Q[-1]}. Holds no state.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             qm1_next,
    output logic             op_active
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    op_t            op;

    // A is one bit wider than M so that -2^(WIDTH-1) squared cannot overflow
    assign m_ext = {m[WIDTH-1], m};
    assign op    = booth_decode(q[0], qm1);

    // Add or subtract the multiplicand according to the Booth pair
    always_comb begin
        sum = a;
        case (op)
            ADD:     sum = a + m_ext;
            SUB:     sum = a - m_ext;
            default: sum = a;
        endcase
    end

    // Arithmetic shift right of {sum, q, qm1}; A's MSB is replicated
    assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign qm1_next  = q[0];
    assign op_active = (op != NOP);

endmodule

// File: rtl/booth_mult_seq.sv
// Radix-2 Booth multiply sequencer. Loads the multiplicand register M for
// one cycle, then runs WIDTH Booth steps and pulses done with the signed
// product {A[WIDTH-1:0], Q}. Define BOOTH_OPCNT_EN to add the op_count
// output counting add/sub steps.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    input  logic [WIDTH-1:0]       q_in,
    input  logic [WIDTH-1:0]       m_in,
    output logic                   m_load_en,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
`ifdef BOOTH_OPCNT_EN
    ,
    output logic [$clog2(WIDTH):0] op_count
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qm1_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             qm1_next;
    logic             op_active;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .qm1       (qm1_reg),
        .m         (m_in),
        .a_next    (a_next),
        .q_next    (q_next),
        .qm1_next  (qm1_next),
        .op_active (op_active)
    );

    // Product reflects the working registers; it only changes at LOAD and
    // during CALC, so it holds from done until the next LOAD edge
    assign product = {a_reg[WIDTH-1:0], q_reg};

    // Sequencer FSM with registered control outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            qm1_reg   <= 1'b0;
            cnt_reg   <= '0;
            m_load_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD;
                        m_load_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    q_reg     <= q_in;
                    a_reg     <= '0;
                    qm1_reg   <= 1'b0;
                    cnt_reg   <= '0;
                    m_load_en <= 1'b0;
                    state_reg <= CALC;
                end
                CALC: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    qm1_reg <= qm1_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef BOOTH_OPCNT_EN
    // Count Booth steps that performed an add or subtract
    always_ff @(posedge clk) begin
        if (rst_b) begin
            op_count <= '0;
        end else if (state_reg == LOAD) begin
            op_count <= '0;
        end else if (state_reg == CALC && op_active) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: products, latency, held start,
// reset mid-operation, and op_count when BOOTH_OPCNT_EN is defined.
module tb_booth_mult_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst_b;
    logic           start;
    logic [W-1:0]   q_in;
    logic [W-1:0]   m_in;
    logic           m_load_en;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef BOOTH_OPCNT_EN
    logic [$clog2(W):0] op_count;
`endif

    int total;
    int bad;

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .q_in      (q_in),
        .m_in      (m_in),
        .m_load_en (m_load_en),
        .busy      (busy),
        .done      (done),
        .product   (product)
`ifdef BOOTH_OPCNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full multiply: checks load pulse, latency, product, op count, done pulse
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp_p, input int exp_ops);
        int n;
        m_in  = m;
        q_in  = q;
        start = 1'b1;
        tick();                           // E0: start sampled
        start = 1'b0;
        check("load_en_hi", m_load_en, 1);
        check("busy_hi", busy, 1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (n == 1) check("load_en_lo", m_load_en, 0);
        end
        check("latency", n, 9);
        check("product", product, exp_p);
`ifdef BOOTH_OPCNT_EN
        check("op_count", op_count, exp_ops);
`endif
        tick();
        check("done_pulse", done, 0);
        check("busy_lo", busy, 0);
        check("product_hold", product, exp_p);
    endtask

    logic [7:0]  tv_m [6];
    logic [7:0]  tv_q [6];
    logic [15:0] tv_p [6];
    int          tv_o [6];

    initial begin
        int n;
        int ndone;
        int first_done;
        int second_done;

        total = 0;
        bad   = 0;
        start = 1'b0;
        q_in  = '0;
        m_in  = '0;
        rst_b = 1'b1;

        tv_m[0] = 8'd7;   tv_q[0] = 8'd3;    tv_p[0] = 16'h0015; tv_o[0] = 2;
        tv_m[1] = 8'hF8;  tv_q[1] = 8'd5;    tv_p[1] = 16'hFFD8; tv_o[1] = 4;
        tv_m[2] = 8'h80;  tv_q[2] = 8'h80;   tv_p[2] = 16'h4000; tv_o[2] = 1;
        tv_m[3] = 8'h7F;  tv_q[3] = 8'hFF;   tv_p[3] = 16'hFF81; tv_o[3] = 1;
        tv_m[4] = 8'd3;   tv_q[4] = 8'h55;   tv_p[4] = 16'h00FF; tv_o[4] = 8;
        tv_m[5] = 8'd3;   tv_q[5] = 8'h00;   tv_p[5] = 16'h0000; tv_o[5] = 0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load_en", m_load_en, 0);
        check("rst_product", product, 0);
`ifdef BOOTH_OPCNT_EN
        check("rst_op_count", op_count, 0);
`endif
        rst_b = 1'b0;
        tick();
        check("no_done_after_rst", done, 0);

        // Directed products
        for (int i = 0; i < 6; i++) begin
            run_op(tv_m[i], tv_q[i], tv_p[i], tv_o[i]);
        end

        // start held high: one op per 11-cycle period, product held through IDLE
        m_in  = 8'd2;
        q_in  = 8'd3;
        start = 1'b1;
        ndone = 0;
        first_done  = -1;
        second_done = -1;
        for (n = 1; n <= 25; n++) begin
            tick();
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
            if (n == 12) check("held_product", product, 16'h0006);
        end
        start = 1'b0;
        check("held_ndone", ndone, 2);
        check("held_first", first_done, 10);
        check("held_second", second_done, 21);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("held_drain", busy, 0);

        // Reset in the 4th CALC cycle
        m_in  = 8'd7;
        q_in  = 8'd3;
        start = 1'b1;
        tick();                 // E0
        start = 1'b0;
        tick();                 // E1: LOAD done, 1st CALC cycle
        tick();
        tick();
        tick();                 // 4th CALC cycle
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_product", product, 0);
        check("midrst_load_en", m_load_en, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // Normal operation after mid-op reset
        run_op(8'hFD, 8'd4, 16'hFFF4, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
